// File: rtl/clint_timer_pkg.sv
// Shared definitions for the CLINT timer: register offsets inside the
// 64 KiB window, reset constants, the bus-side state encoding, and the
// offset-alignment helper.
package clint_timer_pkg;

    localparam logic [15:0] MTIMECMP_OFF   = 16'h4000;
    localparam logic [15:0] MTIME_OFF      = 16'hBFF8;
    localparam logic [15:0] MSIP_OFF       = 16'h0000;
    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // Registers are 64-bit aligned, so the low three address bits never matter.
    function automatic logic [15:0] word_offset(input logic [15:0] byte_off);
        return byte_off & 16'hFFF8;
    endfunction

endpackage

// File: rtl/clint_mtime_counter.sv
// Prescaler plus 64-bit mtime counter. The prescaler runs 0..TICK_DIV-1 and
// mtime advances on the wrap cycle. A load (with any byte enabled) replaces
// mtime, restarts the prescaler and suppresses that cycle's increment.
module clint_mtime_counter #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick_en,
    input  logic        load,
    input  logic [63:0] load_data,
    input  logic [7:0]  load_mask,
    output logic [63:0] mtime
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;

    // Next-state: a load takes priority over the tick; otherwise advance the prescaler.
    always_comb begin
        presc_d = presc_q;
        mtime_d = mtime_q;
        if (load && (|load_mask)) begin
            mtime_d = load_data;
            presc_d = 16'd0;
        end else if (tick_en) begin
            if (presc_q == TICK_LAST) begin
                presc_d = 16'd0;
                mtime_d = mtime_q + 64'd1;
            end else begin
                presc_d = presc_q + 16'd1;
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= 16'd0;
            mtime_q <= 64'd0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime = mtime_q;

endmodule

// File: rtl/clint_timer.sv
// CLINT machine timer: mtime/mtimecmp behind a single-outstanding
// request/response bus, producing the timer-pending level for the CSR unit.
// Optional msip register is built when CLINT_MSIP_EN is defined.
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mtime_bigger_mtimecmp,
    output logic [63:0] mtime_o
`ifdef CLINT_MSIP_EN
    ,
    output logic        msip_o
`endif
);

`ifdef CLINT_MSIP_EN
    localparam bit MSIP_EN = 1'b1;
`else
    localparam bit MSIP_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
`ifdef CLINT_MSIP_EN
    logic        msip_q, msip_d;
`endif

    logic [15:0] offset;
    logic        in_window, hit_cmp, hit_mtime, hit_msip, hit_any;
    logic        accept, mtime_load;
    logic [63:0] wbits, cmp_merged, mtime_merged;

    // Address decode: upper bits select the window, aligned offset selects the register.
    assign offset    = word_offset(req_addr[15:0]);
    assign in_window = (req_addr[63:16] == BASE_ADDR[63:16]);
    assign hit_cmp   = in_window && (offset == MTIMECMP_OFF);
    assign hit_mtime = in_window && (offset == MTIME_OFF);
    assign hit_msip  = MSIP_EN && in_window && (offset == MSIP_OFF);
    assign hit_any   = hit_cmp || hit_mtime || hit_msip;

    // Expand the byte enables into a bit mask for the read-modify-write merge.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_wbits
            assign wbits[gi*8 +: 8] = {8{req_wmask[gi]}};
        end
    endgenerate

    assign cmp_merged   = (mtimecmp_q & ~wbits) | (req_wdata & wbits);
    assign mtime_merged = (mtime_o    & ~wbits) | (req_wdata & wbits);

    assign accept     = req_valid && (state_q == IDLE);
    assign mtime_load = accept && req_wen && hit_mtime;

    clint_mtime_counter #(
        .TICK_DIV (TICK_DIV)
    ) u_counter (
        .clock     (clock),
        .reset     (reset),
        .tick_en   (1'b1),
        .load      (mtime_load),
        .load_data (mtime_merged),
        .load_mask (req_wmask),
        .mtime     (mtime_o)
    );

    // Bus FSM: accept in IDLE, capture the response and commit writes, hold in RESP until taken.
    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mtimecmp_d   = mtimecmp_q;
`ifdef CLINT_MSIP_EN
        msip_d       = msip_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d      = RESP;
                    resp_rdata_d = 64'd0;
                    resp_err_d   = !hit_any;
                    if (req_wen) begin
                        if (hit_cmp) begin
                            mtimecmp_d = cmp_merged;
                        end
`ifdef CLINT_MSIP_EN
                        if (hit_msip && req_wmask[0]) begin
                            msip_d = req_wdata[0];
                        end
`endif
                    end else begin
                        if (hit_cmp) begin
                            resp_rdata_d = mtimecmp_q;
                        end else if (hit_mtime) begin
                            resp_rdata_d = mtime_o;
                        end
`ifdef CLINT_MSIP_EN
                        else if (hit_msip) begin
                            resp_rdata_d = {63'd0, msip_q};
                        end
`endif
                    end
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus-side and register state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
            mtimecmp_q   <= MTIMECMP_RESET;
`ifdef CLINT_MSIP_EN
            msip_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mtimecmp_q   <= mtimecmp_d;
`ifdef CLINT_MSIP_EN
            msip_q       <= msip_d;
`endif
        end
    end

    assign req_ready             = (state_q == IDLE);
    assign resp_valid            = (state_q == RESP);
    assign resp_rdata            = resp_rdata_q;
    assign resp_err              = resp_err_q;
    assign mtime_bigger_mtimecmp = (mtime_o >= mtimecmp_q);
`ifdef CLINT_MSIP_EN
    assign msip_o                = msip_q;
`endif

endmodule
